// File: rtl/sr_drive_ctrl.sv
// rtl/sr_drive_ctrl.sv - Sequences set/reset pulses into an enabled SR latch and checks its readback.
module sr_drive_ctrl #(
    parameter int SETUP_W   = 1,
    parameter int PULSE_W   = 2,
    parameter int HOLD_W    = 1,
    parameter bit SKIP_SAME = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_data,
    output logic req_ready,
    output logic S,
    output logic R,
    output logic enable,
    input  logic q_fb,
    output logic done,
    output logic err
);
    localparam int MAX_SP = (SETUP_W > PULSE_W) ? SETUP_W : PULSE_W;
    localparam int MAX_W  = (MAX_SP > HOLD_W) ? MAX_SP : HOLD_W;
    localparam int CW     = $clog2(MAX_W + 1);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          d, d_nxt;
    logic          skip, skip_nxt;
    logic          known, known_nxt;
    logic          level, level_nxt;
    logic          s_nxt, r_nxt, en_nxt, done_nxt, err_nxt;
    logic          accept, skip_hit, last;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && (state == IDLE);
    assign skip_hit  = SKIP_SAME && known && (level == req_data);
    assign last      = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            d      <= 1'b0;
            skip   <= 1'b0;
            known  <= 1'b0;
            level  <= 1'b0;
            S      <= 1'b0;
            R      <= 1'b0;
            enable <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            d      <= d_nxt;
            skip   <= skip_nxt;
            known  <= known_nxt;
            level  <= level_nxt;
            S      <= s_nxt;
            R      <= r_nxt;
            enable <= en_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (skip_hit) begin
                        state_nxt = CHECK;
                        cnt_nxt   = CW'(1);
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(SETUP_W);
                    end
                end
            end
            SETUP: begin
                if (last) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CW'(PULSE_W);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (last) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(HOLD_W);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (last) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CW'(1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CHECK:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next state; q_fb is therefore sampled on the edge into CHECK.
    always_comb begin
        d_nxt     = accept ? req_data : d;
        skip_nxt  = accept ? skip_hit : skip;
        known_nxt = known;
        level_nxt = level;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        en_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state_nxt)
            SETUP, HOLD: begin
                s_nxt = d_nxt;
                r_nxt = ~d_nxt;
            end
            PULSE: begin
                s_nxt  = d_nxt;
                r_nxt  = ~d_nxt;
                en_nxt = 1'b1;
            end
            CHECK: begin
                done_nxt = 1'b1;
                if (!skip_nxt) begin
                    err_nxt   = (q_fb != d_nxt);
                    known_nxt = 1'b1;
                    level_nxt = d_nxt;
                end
            end
            default: ;
        endcase
    end

    sr_exclusive: assert property (@(posedge clk) disable iff (!rst_n) !(S && R));

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// tb/tb_sr_drive_ctrl.sv - Table and scoreboard bench for sr_drive_ctrl.
module tb_sr_drive_ctrl;
    localparam int SW = 1, PW = 2, HW = 1;
    localparam int ACT = SW + PW + HW;

    typedef struct { logic d; logic q; logic skip; logic err; } vec_t;
    typedef struct { int start; int due; logic d; logic skip; logic err; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_data = 1'b0, q_fb = 1'b0;
    logic req_ready, S, R, enable, done, err;
    logic v6 = 1'b0, d6 = 1'b0, q6 = 1'b0;
    logic rdy6, s6, r6, en6, dn6, er6;

    int   nvec = 0, nerr = 0, cyc = 0;
    int   m_busy = 0, m_acc = 0;
    logic m_known = 1'b0, m_level = 1'b0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sr_drive_ctrl #(.SETUP_W(SW), .PULSE_W(PW), .HOLD_W(HW), .SKIP_SAME(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .S(S), .R(R), .enable(enable), .q_fb(q_fb),
        .done(done), .err(err)
    );

    sr_drive_ctrl #(.SETUP_W(3), .PULSE_W(1), .HOLD_W(2), .SKIP_SAME(1'b1)) dut6 (
        .clk(clk), .rst_n(rst_n), .req_valid(v6), .req_data(d6),
        .req_ready(rdy6), .S(s6), .R(r6), .enable(en6), .q_fb(q6),
        .done(dn6), .err(er6)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: accepts, skip decision and expected completion pushed at the accept edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 0;
            m_known <= 1'b0;
            sb.delete();
        end else begin
            cyc <= cyc + 1;
            if (m_busy > 0) begin
                m_busy <= m_busy - 1;
            end else if (req_valid) begin
                m_acc <= m_acc + 1;
                if (m_known && (m_level == req_data)) begin
                    sb.push_back(exp_t'{cyc + 1, cyc + 1, req_data, 1'b1, 1'b0});
                    m_busy <= 1;
                end else begin
                    sb.push_back(exp_t'{cyc + 1, cyc + 1 + ACT, req_data, 1'b0, q_fb != req_data});
                    m_busy  <= ACT + 1;
                    m_known <= 1'b1;
                    m_level <= req_data;
                end
            end
        end
    end

    always @(negedge clk) begin : mon
        logic [4:0] exp_o;
        int p;
        exp_o = '0;
        if (sb.size() > 0) begin
            p = cyc - sb[0].start;
            if (!sb[0].skip && p < ACT) exp_o[4:3] = sb[0].d ? 2'b10 : 2'b01;
            if (!sb[0].skip && p >= SW && p < SW + PW) exp_o[2] = 1'b1;
            if (cyc == sb[0].due) begin
                exp_o[1] = 1'b1;
                exp_o[0] = sb[0].err;
            end
        end
        chk("outputs_SRen_done_err", 8'({S, R, enable, done, err}), 8'(exp_o));
        chk("ready", 8'(req_ready), 8'(sb.size() == 0));
        chk("sr_exclusive", 8'((S && R) || (s6 && r6)), 8'(0));
        if (sb.size() > 0 && cyc >= sb[0].due) void'(sb.pop_front());
    end

    task automatic send(input logic d, input logic q, output logic got_err, output logic got_pulse);
        int n;
        chk("send_ready", 8'(req_ready), 8'(1));
        req_valid = 1'b1;
        req_data  = d;
        q_fb      = q;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_data  = 1'($urandom_range(0, 1));
        got_pulse = 1'b0;
        got_err   = 1'b0;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            if (enable) got_pulse = 1'b1;
            if (done) break;
            n++;
        end
        if (n >= 12) chk("done_timeout", 8'(0), 8'(1));
        got_err = err;
        @(posedge clk); #1;
    endtask

    vec_t tv[8];
    logic e, pl, alt;
    int   a0, n;

    initial begin
        tv[0] = vec_t'{1'b1, 1'b1, 1'b0, 1'b0};
        tv[1] = vec_t'{1'b1, 1'b1, 1'b1, 1'b0};
        tv[2] = vec_t'{1'b0, 1'b1, 1'b0, 1'b1};
        tv[3] = vec_t'{1'b0, 1'b1, 1'b1, 1'b0};
        tv[4] = vec_t'{1'b1, 1'b0, 1'b0, 1'b1};
        tv[5] = vec_t'{1'b1, 1'b1, 1'b1, 1'b0};
        tv[6] = vec_t'{1'b0, 1'b0, 1'b0, 1'b0};
        tv[7] = vec_t'{1'b1, 1'b1, 1'b0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 8'({S, R, enable, done, err, req_ready}), 8'(6'b000001));
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            send(tv[i].d, tv[i].q, e, pl);
            chk($sformatf("vec%0d_err", i), 8'(e), 8'(tv[i].err));
            chk($sformatf("vec%0d_pulse", i), 8'(pl), 8'(!tv[i].skip));
        end

        // Asynchronous reset in the middle of PULSE.
        req_valid = 1'b1;
        req_data  = 1'b0;
        q_fb      = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!enable && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("pulse_reached", 8'(enable), 8'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", 8'({S, R, enable, done, req_ready}), 8'(5'b00001));
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(1'b1, 1'b1, e, pl);
        chk("post_reset_no_skip", 8'(pl), 8'(1));
        chk("post_reset_err", 8'(e), 8'(0));

        // Continuous valid: accepted data alternates, data noise in between.
        q_fb = 1'b1;
        alt  = ~m_level;
        a0   = m_acc;
        for (int i = 0; i < 36; i++) begin
            if (m_busy == 0) begin
                req_data = alt;
                alt = ~alt;
            end else begin
                req_data = 1'($urandom_range(0, 1));
            end
            req_valid = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("throughput_accepts", 8'(m_acc - a0), 8'(6));

        // Alternate timing: SETUP_W=3, PULSE_W=1, HOLD_W=2.
        for (int k = 0; k < 2; k++) begin
            logic dd;
            dd = (k == 0);
            chk("t6_ready", 8'(rdy6), 8'(1));
            v6 = 1'b1;
            d6 = dd;
            q6 = dd;
            @(posedge clk); #1;
            v6 = 1'b0;
            for (int p = 0; p < 7; p++) begin
                @(negedge clk);
                chk($sformatf("t6_d%0d_p%0d", dd, p), 8'({s6, r6, en6, dn6, er6, rdy6}),
                    8'({dd && p < 6, !dd && p < 6, p == 3, p == 6, 1'b0, 1'b0}));
            end
            @(negedge clk);
            chk("t6_ready_back", 8'(rdy6), 8'(1));
            @(posedge clk); #1;
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
